// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bus between producers, the arbiter and the downstream sync FIFO.
// master: producer/FIFO side (drives requests and pop feedback).
// slave:  arbiter side (drives ready, FIFO write and status).
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int OW = $clog2(FIFO_DEPTH + 1);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_pop;
  logic                          fifo_we;
  logic [DATA_WIDTH-1:0]         fifo_w_data;
  logic [GW-1:0]                 grant_id;
  logic                          busy;
  logic [OW-1:0]                 occupancy;

  modport master (
    output req_valid, req_last, req_data, fifo_pop,
    input  req_ready, fifo_we, fifo_w_data, grant_id, busy, occupancy
  );

  modport slave (
    input  req_valid, req_last, req_data, fifo_pop,
    output req_ready, fifo_we, fifo_w_data, grant_id, busy, occupancy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-side controller sharing one sync FIFO write port among
// NUM_REQ producers. One requester is granted per burst (up to BURST_MAX
// beats); accepted words are registered onto fifo_we/fifo_w_data. A local
// credit counter tracks FIFO fill so the FIFO is never overrun.
// Optional feature: define FIFO_WR_ARB_STATS_EN to add per-requester
// 16-bit accepted-beat counters on stat_beats.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int BURST_MAX  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  fifo_wr_arbiter_if.slave        bus
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]   stat_beats
`endif
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int OW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = $clog2(BURST_MAX + 1);

  typedef enum logic {IDLE, XFER} state_t;

  state_t                state;
  logic [GW-1:0]         rr_ptr;
  logic [GW-1:0]         grant;
  logic [BW-1:0]         beat_cnt;
  logic [OW-1:0]         occ;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic                  has_credit;
  logic                  grant_valid;
  logic                  grant_last;
  logic [DATA_WIDTH-1:0] grant_data;
  logic                  accept;
  logic                  burst_full;
  logic                  leave;
  logic                  pop_eff;
  logic [GW-1:0]         next_ptr;
  logic [GW-1:0]         pick;
  logic [NUM_REQ-1:0]    ready;

  assign has_credit  = (occ < OW'(FIFO_DEPTH));
  assign grant_valid = bus.req_valid[grant];
  assign grant_last  = bus.req_last[grant];
  assign grant_data  = bus.req_data[grant*DATA_WIDTH +: DATA_WIDTH];
  assign accept      = (state == XFER) && grant_valid && has_credit;
  // This accept is the BURST_MAX-th beat of the grant.
  assign burst_full  = (beat_cnt == BW'(BURST_MAX - 1));
  assign leave       = (state == XFER) &&
                       (!grant_valid || (accept && (grant_last || burst_full)));
  assign pop_eff     = bus.fifo_pop && (occ != '0);
  assign next_ptr    = (grant == GW'(NUM_REQ - 1)) ? '0 : grant + GW'(1);

  // Ready for the granted requester only, while credit is available
  always_comb begin
    ready = '0;
    if (state == XFER && has_credit) ready[grant] = 1'b1;
  end

  // First valid requester at or after the round-robin pointer, wrapping
  always_comb begin
    logic          found;
    logic [GW:0]   sum;
    pick  = '0;
    found = 1'b0;
    sum   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, rr_ptr} + (GW+1)'(i);
      if (sum >= (GW+1)'(NUM_REQ)) sum = sum - (GW+1)'(NUM_REQ);
      if (!found && bus.req_valid[sum[GW-1:0]]) begin
        found = 1'b1;
        pick  = sum[GW-1:0];
      end
    end
  end

  // Arbitration FSM: one-cycle pick in IDLE, bounded burst in XFER
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|bus.req_valid) begin
            grant    <= pick;
            beat_cnt <= '0;
            state    <= XFER;
          end
        end
        XFER: begin
          if (accept) beat_cnt <= beat_cnt + BW'(1);
          if (leave) begin
            state  <= IDLE;
            rr_ptr <= next_ptr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Credit counter: +1 per accept, -1 per pop, pop at zero ignored
  always_ff @(posedge clk) begin
    if (rst) begin
      occ <= '0;
    end else if (accept && !pop_eff) begin
      occ <= occ + OW'(1);
    end else if (!accept && pop_eff) begin
      occ <= occ - OW'(1);
    end
  end

  // Registered FIFO write port; data holds when no beat is written
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      we_q <= accept;
      if (accept) wdata_q <= grant_data;
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  // Per-requester accepted-beat counters, wrapping at 16 bits
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_beats <= '0;
    end else if (accept) begin
      stat_beats[grant*16 +: 16] <= stat_beats[grant*16 +: 16] + 16'd1;
    end
  end
`endif

  assign bus.req_ready   = ready;
  assign bus.fifo_we     = we_q;
  assign bus.fifo_w_data = wdata_q;
  assign bus.grant_id    = grant;
  assign bus.busy        = (state == XFER);
  assign bus.occupancy   = occ;
endmodule
